// File: rtl/count_seq_pkg.sv
// Shared types and constants for the run/pause/clear count sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } count_seq_state_t;

    localparam int DIGIT_W = 3;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 3'h7;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Operator requests, digit read-back and counter-chain controls of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; requests are edge-triggered levels, controls are unconditional.
interface count_seq_ctrl_if #(
    parameter int DIGITS = 2
);
    import count_seq_pkg::*;

    logic                        Start;
    logic                        Stop;
    logic                        Clear;
    logic [DIGIT_W*DIGITS-1:0]   Qin;
    logic [DIGITS-1:0]           En;
    logic                        R;
    logic                        Run;
    logic                        Done;

    modport master (
        output Start, Stop, Clear, Qin,
        input  En, R, Run, Done
    );

    modport slave (
        input  Start, Stop, Clear, Qin,
        output En, R, Run, Done
    );

endinterface

// File: rtl/count_seq_ctrl_btn_edge.sv
// Rising-edge detector for one debounced request level.
// Latency: combinational pulse in the cycle the level first reads high.
// Backpressure: none; prev resets to 1 so a level held through reset never fires.
module btn_edge (
    input  logic Clk,
    input  logic Rn,
    input  logic d,
    output logic pulse
);

    logic prev;

    always_ff @(posedge Clk or negedge Rn) begin
        if (!Rn) begin
            prev <= 1'b1;
        end else begin
            prev <= d;
        end
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/count_seq_ctrl.sv
// Run/pause/clear FSM, tick prescaler and ripple-carry enables; COUNT_SEQ_AUTOSTOP_EN adds DONE.
// Latency: request edge acts at the next Clk edge; En is combinational from state/pre/Qin.
// Backpressure: none; Clear > Stop > Start when request edges coincide.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int DIV    = 1000,
    parameter int DIGITS = 2
) (
    input  logic             Clk,
    input  logic             Rn,
    count_seq_ctrl_if.slave  bus
);

    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic start_pls;
    logic stop_pls;
    logic clr_pls;

    btn_edge u_start (.Clk(Clk), .Rn(Rn), .d(bus.Start), .pulse(start_pls));
    btn_edge u_stop  (.Clk(Clk), .Rn(Rn), .d(bus.Stop),  .pulse(stop_pls));
    btn_edge u_clear (.Clk(Clk), .Rn(Rn), .d(bus.Clear), .pulse(clr_pls));

    count_seq_state_t   state;
    logic [PRE_W-1:0]   pre;
    logic               r_q;
    logic               run_q;
    logic               tick;
    logic [DIGITS-1:0]  carry;
    logic [DIGITS-1:0]  en_raw;

    assign tick = (state == RUN) && (pre == PRE_LAST);

    // carry[k]: every digit below k sits at its maximum
    assign carry[0] = 1'b1;
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_carry
            assign en_raw[k] = tick && carry[k];
            if (k > 0) begin : g_link
                assign carry[k] = carry[k-1] &&
                                  (bus.Qin[DIGIT_W*(k-1) +: DIGIT_W] == DIGIT_MAX);
            end
        end
    endgenerate

`ifdef COUNT_SEQ_AUTOSTOP_EN
    logic done_q;
    logic all_max;

    assign all_max = carry[DIGITS-1] &&
                     (bus.Qin[DIGIT_W*(DIGITS-1) +: DIGIT_W] == DIGIT_MAX);
    assign bus.En   = (tick && all_max) ? '0 : en_raw;
    assign bus.Done = done_q;
`else
    assign bus.En   = en_raw;
    assign bus.Done = 1'b0;
`endif

    assign bus.R   = r_q;
    assign bus.Run = run_q;

    always_ff @(posedge Clk or negedge Rn) begin
        if (!Rn) begin
            state <= IDLE;
            pre   <= '0;
            r_q   <= 1'b1;
            run_q <= 1'b0;
`ifdef COUNT_SEQ_AUTOSTOP_EN
            done_q <= 1'b0;
`endif
        end else begin
            r_q <= 1'b0;
            if (clr_pls) begin
                state <= IDLE;
                pre   <= '0;
                r_q   <= 1'b1;
                run_q <= 1'b0;
`ifdef COUNT_SEQ_AUTOSTOP_EN
                done_q <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        pre <= '0;
                        if (!stop_pls && start_pls) begin
                            state <= RUN;
                            run_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop_pls) begin
                            state <= PAUSE;
                            run_q <= 1'b0;
                            // a tick consumed on the stop edge must not repeat on resume
                            if (tick) begin
                                pre <= '0;
                            end
`ifdef COUNT_SEQ_AUTOSTOP_EN
                        end else if (tick && all_max) begin
                            state  <= DONE;
                            run_q  <= 1'b0;
                            done_q <= 1'b1;
`endif
                        end else begin
                            pre <= tick ? '0 : pre + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (!stop_pls && start_pls) begin
                            state <= RUN;
                            run_q <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE: only Clear leaves
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Run/pause/clear sequencer for a chain of `DIGITS` cascaded 3-bit (0..7) digit counters. It turns operator Start/Stop/Clear pulses into a run-state FSM and divides `Clk` into a count tick. It drives the per-digit `En` and shared synchronous `R` inputs of the counter chain, and computes ripple-carry enables from the digit values read back. It sits between the button front-end and the counter datapath.

## Interface
- `DIV`, default 1000: clock cycles per count tick; legal range ≥2.
- `DIGITS`, default 2: number of cascaded 3-bit digit counters; legal range ≥1.
- `Clk  in  1`: single clock; all state changes on its rising edge.
- `Rn  in  1`: asynchronous, active-low reset.
- `Start  in  1`: run request. Level input, synchronous, debounced upstream; acts on its rising edge.
- `Stop  in  1`: pause request. Rising edge acts.
- `Clear  in  1`: clear request. Rising edge acts.
- `Qin  in  3*DIGITS`: current digit values; digit k is `Qin[3k+2:3k]`.
- `En  out  DIGITS`: per-digit count enable, to the counters' `En`.
- `R  out  1`: synchronous clear to all counters, registered.
- `Run  out  1`: high while the FSM is in RUN.
- `Done  out  1`: high in DONE; constant 0 without the macro.

## Operation
- Edge detect: `edge = in & ~prev`. `prev` registers reset to 1, so a button held through reset does not fire.
- Request priority when edges coincide: Clear > Stop > Start.
- FSM states:
  - IDLE: reset state.
  - RUN.
  - PAUSE.
  - DONE: exists only with the macro.
- FSM transitions:
  - IDLE –Start→ RUN.
  - RUN –Stop→ PAUSE.
  - PAUSE –Start→ RUN.
  - Any state –Clear→ IDLE, with `R` pulsed for exactly one cycle.
  - Start in RUN and Stop in IDLE/PAUSE are ignored.
- Prescaler `pre`, width `$clog2(DIV)`:
  - Counts 0..DIV-1 in RUN, wrapping to 0.
  - Holds in PAUSE and DONE.
  - Forced to 0 in IDLE and on Clear.
- `Tick = (state==RUN) && (pre==DIV-1)`, combinational from registers.
- `En[0] = Tick`. `En[k] = Tick && all digits j<k equal 3'h7` (combinational carry).
- Wrap: all digits 7 at Tick → all `En` high, so the counter chain rolls over to 0.

## Timing
- Reset values (while `Rn` low):
  - state IDLE, `pre`=0.
  - `R`=1, so counters are held cleared.
  - `En`=0, `Run`=0, `Done`=0.
  - `prev`=all 1.
- `R` falls at the first `Clk` edge after `Rn` rises.
- A Start edge sampled at edge t gives `Run`=1 after edge t.
- First `Tick` is high during the cycle after edge t+DIV-1; the counter increments at edge t+DIV. Subsequent ticks occur every DIV cycles.
- Stop at edge s: `Run`=0 after s. `pre` freezes, and no `En` is asserted in the cycle after s.
- Resume: the remaining tick phase is preserved.
- Clear at edge c: state IDLE and `pre`=0 after c. `R`=1 for the cycle after c only. `En`=0.
- Reset mid-run: immediate asynchronous return to the reset values above.

## Configuration
- `COUNT_SEQ_AUTOSTOP_EN`:
  - Defined: a `Tick` with all digits at 7 suppresses every `En` in that cycle. The FSM enters DONE and `Done`=1; counters hold at all-7. In DONE, Start and Stop are ignored and only Clear exits.
  - Undefined: no DONE state and `Done` is tied to 0. The counters wrap freely.

## Structure
- Package `count_seq_pkg` holds:
  - state enum `count_seq_state_t` (IDLE, RUN, PAUSE, DONE);
  - `DIGIT_W`=3 and `DIGIT_MAX`=3'h7.
- Sub-module `btn_edge`: one instance per request input. It contains the `prev` register, resets to 1, and outputs a one-cycle rising-edge pulse.
- Carry logic is a generate loop in the top module.

## Test plan
All scenarios use `DIV`=4, `DIGITS`=2, and a behavioural counter model fed back on `Qin`.
- Reset: hold `Rn` low → `R`=1, `En`=00, `Run`=0. Release → `R`=0 after the next edge.
- Start, run 12 cycles from `Qin`=00 → `En[0]` pulses every 4th cycle; `Qin` reaches 03.
- Carry: `Qin`=07 at `Tick` → `En`=2'b11 → `Qin` becomes 10 (octal).
- Pause/resume: Stop at `pre`=2 for 10 cycles → `En`=0 and `pre` stays 2. Start → the next `Tick` arrives 1 cycle later.
- Simultaneous Clear+Start in RUN → IDLE, `R` pulse lasts 1 cycle, `Run`=0, `Qin`=00, `pre`=0.
- Terminal count, `Qin`=77 at `Tick`:
  - With `COUNT_SEQ_AUTOSTOP_EN`: `En`=00, `Done`=1, Start ignored, Clear → IDLE.
  - Without the macro: `En`=11, `Qin` becomes 00, `Run` stays 1.
